// File: rtl/fetch_sequencer.sv
// Fetch sequencer for a dual-bank (even/odd halfword) Thumb program ROM.
// Holds the fetch PC, drives the ROM row address, the odd-alignment bit and the
// IR_0/IR_1 mux selects, advances by the decoder's issue count, and inserts
// flush bubbles after a taken redirect.
module fetch_sequencer #(
  parameter int ADDR_W    = 14,
  parameter int RESET_PC  = 0,
  parameter int FLUSH_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              br_valid,
  input  logic [ADDR_W+1:0] br_target,
  input  logic [1:0]        issue_cnt,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              pc_1,
  output logic              sel_mem_1,
  output logic [1:0]        sel_mem_0,
  output logic              fetch_valid,
  output logic [ADDR_W+1:0] pc_out,
  output logic              issue_err
);

  localparam int PC_W = ADDR_W + 2;

  // Halfword alignment mask: the Thumb bit never reaches the PC register.
  localparam logic [PC_W-1:0] PC_MASK = ~PC_W'(1);
  localparam logic [PC_W-1:0] PC_INIT = PC_W'(RESET_PC) & PC_MASK;
  localparam logic [2:0]      FLUSH_INIT = 3'(FLUSH_CYC);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [2:0]      flush_cnt_q, flush_cnt_d;
  logic            issue_err_q, issue_err_d;

  logic [PC_W-1:0] br_pc;
  logic [PC_W-1:0] pc_step;
  logic            issue_bad;

  assign br_pc     = br_target & PC_MASK;
  assign issue_bad = (issue_cnt == 2'd3);
  // Each issued Thumb instruction is one halfword; issue_cnt=3 is treated as 0.
  assign pc_step   = issue_bad ? '0 : PC_W'({issue_cnt, 1'b0});

  // Next-state, PC and flush-counter logic; br_valid overrides issue_cnt and en.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    flush_cnt_d = flush_cnt_q;
    issue_err_d = issue_err_q;
    case (state_q)
      ST_IDLE: begin
        if (br_valid) begin
          // Redirect while parked only moves the PC; no bubble is needed.
          pc_d = br_pc;
        end else if (en) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (br_valid) begin
          pc_d        = br_pc;
          flush_cnt_d = FLUSH_INIT;
          state_d     = ST_FLUSH;
        end else begin
          pc_d = pc_q + pc_step;
          if (issue_bad) begin
            issue_err_d = 1'b1;
          end
          if (!en) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_FLUSH: begin
        if (br_valid) begin
          // A second redirect restarts the bubble from the new target.
          pc_d        = br_pc;
          flush_cnt_d = FLUSH_INIT;
        end else if (flush_cnt_q <= 3'd1) begin
          flush_cnt_d = 3'd0;
          state_d     = en ? ST_FETCH : ST_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q - 3'd1;
        end
      end
      default: begin
        // Unreachable encoding: recover to a parked, bubble-free state.
        state_d     = ST_IDLE;
        flush_cnt_d = 3'd0;
      end
    endcase
  end

  // State registers with asynchronous reset to the parked reset PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= PC_INIT;
      flush_cnt_q <= 3'd0;
      issue_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      flush_cnt_q <= flush_cnt_d;
      issue_err_q <= issue_err_d;
    end
  end

  // ROM addressing and mux selects are pure functions of the current PC.
  // An odd fetch takes IR_0 from bank1 at the row and IR_1 from bank0 at row+1
  // (the ROM computes row+1 with ADDR_W-bit wrap).
  always_comb begin
    rom_addr  = pc_q[PC_W-1:2];
    pc_1      = pc_q[1];
    sel_mem_1 = ~pc_q[1];
    sel_mem_0 = pc_q[1] ? 2'd2 : 2'd0;
  end

  assign fetch_valid = (state_q == ST_FETCH);
  assign pc_out      = pc_q;
  assign issue_err   = issue_err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a vector table for the steady-state flow
// plus hand-written sequences for redirects, illegal issue, wrap and reset.
module tb_fetch_sequencer;

  localparam int ADDR_W = 14;
  localparam int PC_W   = ADDR_W + 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              br_valid;
  logic [PC_W-1:0]   br_target;
  logic [1:0]        issue_cnt;
  logic [ADDR_W-1:0] rom_addr;
  logic              pc_1;
  logic              sel_mem_1;
  logic [1:0]        sel_mem_0;
  logic              fetch_valid;
  logic [PC_W-1:0]   pc_out;
  logic              issue_err;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_sequencer #(.ADDR_W(ADDR_W), .RESET_PC(0), .FLUSH_CYC(1)) dut (
    .clk(clk), .rst(rst), .en(en), .br_valid(br_valid), .br_target(br_target),
    .issue_cnt(issue_cnt), .rom_addr(rom_addr), .pc_1(pc_1), .sel_mem_1(sel_mem_1),
    .sel_mem_0(sel_mem_0), .fetch_valid(fetch_valid), .pc_out(pc_out),
    .issue_err(issue_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            en;
    logic            br;
    logic [PC_W-1:0] tgt;
    logic [1:0]      ic;
    logic            exp_vld;
    logic [PC_W-1:0] exp_pc;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare every output against a PC-derived expectation.
  task automatic chk_all(input string tag, input logic exp_vld,
                         input logic [PC_W-1:0] exp_pc, input logic exp_err);
    logic [ADDR_W-1:0] exp_row;
    logic              exp_odd;
    exp_row = exp_pc[PC_W-1:2];
    exp_odd = exp_pc[1];
    chk({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(exp_vld));
    chk({tag, ".pc_out"},      32'(pc_out),      32'(exp_pc));
    chk({tag, ".rom_addr"},    32'(rom_addr),    32'(exp_row));
    chk({tag, ".pc_1"},        32'(pc_1),        32'(exp_odd));
    chk({tag, ".sel_mem_0"},   32'(sel_mem_0),   exp_odd ? 32'd2 : 32'd0);
    chk({tag, ".sel_mem_1"},   32'(sel_mem_1),   exp_odd ? 32'd0 : 32'd1);
    chk({tag, ".issue_err"},   32'(issue_err),   32'(exp_err));
  endtask

  task automatic drive(input logic e, input logic b, input logic [PC_W-1:0] t,
                       input logic [1:0] c);
    en = e; br_valid = b; br_target = t; issue_cnt = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, 2'd0);
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Steady-state flow starting from reset (pc=0, IDLE), one row per clock.
    vecs[0]  = '{1'b1, 1'b0, 16'h0000, 2'd0, 1'b1, 16'h0000}; // IDLE -> FETCH
    vecs[1]  = '{1'b1, 1'b0, 16'h0000, 2'd2, 1'b1, 16'h0004};
    vecs[2]  = '{1'b1, 1'b0, 16'h0000, 2'd2, 1'b1, 16'h0008};
    vecs[3]  = '{1'b1, 1'b0, 16'h0000, 2'd2, 1'b1, 16'h000C};
    vecs[4]  = '{1'b1, 1'b0, 16'h0000, 2'd1, 1'b1, 16'h000E}; // odd alignment
    vecs[5]  = '{1'b1, 1'b0, 16'h0000, 2'd2, 1'b1, 16'h0012};
    vecs[6]  = '{1'b1, 1'b0, 16'h0000, 2'd0, 1'b1, 16'h0012}; // stall
    vecs[7]  = '{1'b1, 1'b1, 16'h0013, 2'd2, 1'b0, 16'h0012}; // redirect beats issue
    vecs[8]  = '{1'b1, 1'b0, 16'h0000, 2'd2, 1'b1, 16'h0012}; // issue ignored in FLUSH
    vecs[9]  = '{1'b1, 1'b0, 16'h0000, 2'd1, 1'b1, 16'h0014};
    vecs[10] = '{1'b0, 1'b0, 16'h0000, 2'd2, 1'b0, 16'h0018}; // update then park
    vecs[11] = '{1'b0, 1'b0, 16'h0000, 2'd2, 1'b0, 16'h0018}; // issue ignored in IDLE
    vecs[12] = '{1'b0, 1'b1, 16'h0101, 2'd0, 1'b0, 16'h0100}; // redirect while parked
    vecs[13] = '{1'b1, 1'b0, 16'h0000, 2'd0, 1'b1, 16'h0100};
    vecs[14] = '{1'b1, 1'b1, 16'h0040, 2'd0, 1'b0, 16'h0040};
    vecs[15] = '{1'b1, 1'b1, 16'h0022, 2'd0, 1'b0, 16'h0022}; // re-redirect in FLUSH
    vecs[16] = '{1'b0, 1'b0, 16'h0000, 2'd0, 1'b0, 16'h0022}; // flush ends, en=0
    vecs[17] = '{1'b1, 1'b0, 16'h0000, 2'd0, 1'b1, 16'h0022};

    // T1: reset values
    do_reset();
    chk_all("reset", 1'b0, 16'h0000, 1'b0);

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].br, vecs[i].tgt, vecs[i].ic);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].exp_vld, vecs[i].exp_pc, 1'b0);
    end

    // T3: single issue from an aligned PC flips to odd alignment
    do_reset();
    drive(1'b1, 1'b0, '0, 2'd0); step();
    drive(1'b1, 1'b0, '0, 2'd1); step();
    chk_all("t3_odd", 1'b1, 16'h0002, 1'b0);
    drive(1'b1, 1'b0, '0, 2'd2); step();
    chk_all("t3_adv", 1'b1, 16'h0006, 1'b0);

    // T5: illegal issue count holds the PC and sets a sticky error
    drive(1'b1, 1'b0, '0, 2'd3); step();
    chk_all("t5_bad", 1'b1, 16'h0006, 1'b1);
    drive(1'b1, 1'b0, '0, 2'd2); step();
    chk_all("t5_sticky", 1'b1, 16'h000A, 1'b1);
    drive(1'b1, 1'b0, '0, 2'd0); step();
    chk_all("t5_sticky2", 1'b1, 16'h000A, 1'b1);
    // Asynchronous reset pulse between edges clears immediately
    #2 rst = 1'b1;
    #1 chk_all("t5_async_rst", 1'b0, 16'h0000, 1'b0);
    rst = 1'b0;

    // T6: wrap at the top of the address space
    drive(1'b1, 1'b0, '0, 2'd0); step();
    drive(1'b1, 1'b1, 16'hFFFD, 2'd0); step();
    chk_all("t6_br_top", 1'b0, 16'hFFFC, 1'b0);
    drive(1'b1, 1'b0, '0, 2'd0); step();
    chk_all("t6_top", 1'b1, 16'hFFFC, 1'b0);
    drive(1'b1, 1'b0, '0, 2'd1); step();
    chk_all("t6_last_odd", 1'b1, 16'hFFFE, 1'b0);
    drive(1'b1, 1'b0, '0, 2'd1); step();
    chk_all("t6_wrap", 1'b1, 16'h0000, 1'b0);

    // Reset in the middle of a flush discards the pending redirect
    drive(1'b1, 1'b1, 16'h0200, 2'd0); step();
    chk_all("t6_flush", 1'b0, 16'h0200, 1'b0);
    #2 rst = 1'b1;
    #1 chk_all("t6_rst_mid", 1'b0, 16'h0000, 1'b0);
    drive(1'b1, 1'b0, '0, 2'd0);
    step();
    rst = 1'b0;
    chk_all("t6_rst_held", 1'b0, 16'h0000, 1'b0);
    step();
    chk_all("t6_restart", 1'b1, 16'h0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
